// File: rtl/tristate_bus_scanner.sv
// rtl/tristate_bus_scanner.sv - round-robin tri-state bus scanner/arbiter with per-channel capture.
// Optional GUARD turnaround cycle between owners when TBS_GUARD_EN is defined.
module tristate_bus_scanner #(
    parameter int CH    = 4,
    parameter int W     = 4,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic [CH-1:0]          ch_mask,
    input  logic [CH-1:0]          req,
    input  logic [CH*W-1:0]        src_data,
    inout  wire  [W-1:0]           bus,
    output logic [CH-1:0]          drv_en,
    output logic [$clog2(CH)-1:0]  grant_idx,
    output logic [CH*W-1:0]        capture,
    output logic                   cap_stb,
    output logic [$clog2(CH)-1:0]  cap_idx
);

    localparam int GW = $clog2(CH);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

`ifdef TBS_GUARD_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_GUARD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1} state_t;
`endif

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            first_q, first_d;
    logic [CH*W-1:0] capture_q;
    logic            cap_stb_q;
    logic [GW-1:0]   cap_idx_q;

    logic [CH-1:0]   elig;
    logic [GW-1:0]   search_start;
    logic [GW-1:0]   next_owner;
    logic            any_elig;
    logic            slot_end;
    logic            drive_act;

    assign elig = mode ? (ch_mask & req) : ch_mask;

    // Round-robin search from grant+1; the very first search after reset starts at 0.
    always_comb begin
        logic [GW:0] pos;
        search_start = first_q ? '0
                     : ((grant_q == GW'(CH - 1)) ? '0 : grant_q + GW'(1));
        next_owner   = search_start;
        any_elig     = 1'b0;
        pos          = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            pos = {1'b0, search_start} + (GW + 1)'(k);
            if (pos >= (GW + 1)'(CH)) begin
                pos = pos - (GW + 1)'(CH);
            end
            if (elig[pos[GW-1:0]]) begin
                next_owner = pos[GW-1:0];
                any_elig   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            capture_q <= '0;
            cap_stb_q <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            cap_stb_q <= slot_end;
            if (slot_end) begin
                capture_q[grant_q*W +: W] <= bus;
                cap_idx_q                 <= grant_q;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        slot_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en && any_elig) begin
                    state_d = S_DRIVE;
                    grant_d = next_owner;
                    first_d = 1'b0;
                end
            end
            S_DRIVE: begin
                // en low wins over a coinciding slot end: no capture is taken.
                if (!en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    slot_end = 1'b1;
                    cnt_d    = '0;
`ifdef TBS_GUARD_EN
                    state_d  = S_GUARD;
`else
                    if (any_elig) begin
                        grant_d = next_owner;
                    end else begin
                        state_d = S_IDLE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef TBS_GUARD_EN
            S_GUARD: begin
                cnt_d = '0;
                if (en && any_elig) begin
                    state_d = S_DRIVE;
                    grant_d = next_owner;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        drive_act = (state_q == S_DRIVE);
        drv_en    = drive_act ? (CH'(1) << grant_q) : '0;
    end

    assign bus       = drive_act ? src_data[grant_q*W +: W] : {W{1'bz}};
    assign grant_idx = grant_q;
    assign capture   = capture_q;
    assign cap_stb   = cap_stb_q;
    assign cap_idx   = cap_idx_q;

endmodule
